// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and helpers for the elastic pipeline.
//   PIPE_WIDTH / PIPE_DEPTH : default payload width and slot count
//   PIPE_MAX_DEPTH          : largest supported slot count
//   occ_width()             : bit width needed to hold 0..depth
//   popcount()              : number of set bits in a slot-valid vector
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned PIPE_WIDTH     = 32;
    localparam int unsigned PIPE_DEPTH     = 5;
    localparam int unsigned PIPE_MAX_DEPTH = 16;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [4:0] popcount(input logic [PIPE_MAX_DEPTH-1:0] vec);
        logic [4:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < PIPE_MAX_DEPTH; i++) begin
            cnt = cnt + 5'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot of the elastic pipeline: a valid bit plus payload.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : capture load_data_i and mark the slot valid
//   load_data_i  : payload to capture
//   drop_i       : invalidate the slot (ignored when load_i is set)
//   v_o, d_o     : registered valid bit and payload
// Payload only changes on a load; a dropped slot keeps its stale data.
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             drop_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q;
    logic [WIDTH-1:0] d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            if (load_i) begin
                v_q <= 1'b1;
                d_q <= load_data_i;
            end else if (drop_i) begin
                v_q <= 1'b0;
            end
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/elastic_pipe.sv
// -----------------------------------------------------------------------------
// elastic_pipe
// DEPTH-slot valid/ready pipeline with bubble collapse and per-slot flush.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : upstream offers in_data
//   in_ready    : slot 0 can accept this cycle
//   in_data     : upstream payload
//   flush       : flush[i] kills the entry held in slot i this cycle
//   out_valid   : head slot holds a live (unflushed) entry
//   out_ready   : downstream accepts out_data
//   out_data    : payload of the head slot (stale when out_valid=0)
//   occupancy   : registered count of valid slots after the edge
//   stall_cnt   : saturating count of cycles with out_valid & ~out_ready
//   stall_clr   : synchronous clear of stall_cnt (wins over increment)
// -----------------------------------------------------------------------------
module elastic_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_WIDTH,
    parameter int unsigned DEPTH = PIPE_DEPTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    input  logic                       stall_clr
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] v_nxt;

    logic [OCC_W-1:0] occ_q;
    logic [CNT_W-1:0] stall_q, stall_d;

    // Ready chain folded from the head backwards with a running OR so that
    // rdy never reads its own bits.
    always_comb begin
        logic acc;
        acc        = out_ready;
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            acc                = ~v[DEPTH-1-k] | flush[DEPTH-1-k] | acc;
            rdy[DEPTH-1-k]     = acc;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic             ld;
        logic [WIDTH-1:0] ld_data;
        logic             dr;

        // For the head, move is exactly the output transfer.
        assign move[g] = v[g] & ~flush[g] & rdy[g+1];

        if (g == 0) begin : g_first
            assign ld      = in_valid & rdy[0];
            assign ld_data = in_data;
        end else begin : g_rest
            assign ld      = move[g-1];
            assign ld_data = d[g-1];
        end

        assign dr       = flush[g] | move[g];
        assign v_nxt[g] = ld | (v[g] & ~dr);

        pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (ld),
            .load_data_i (ld_data),
            .drop_i      (dr),
            .v_o         (v[g]),
            .d_o         (d[g])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1] & ~flush[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            occ_q   <= OCC_W'(popcount(PIPE_MAX_DEPTH'(v_nxt)));
            stall_q <= stall_d;
        end
    end

    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_elastic_pipe.sv
module tb_elastic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, stall_clr;
    logic [7:0] in_data, out_data;
    logic [4:0] flush;
    logic [2:0] occupancy;
    logic [3:0] stall_cnt;

    logic       i1_valid, i1_ready, o1_valid, o1_ready, clr1;
    logic [7:0] i1_data, o1_data;
    logic [0:0] f1, occ1;
    logic [3:0] st1;

    elastic_pipe #(.WIDTH(8), .DEPTH(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    elastic_pipe #(.WIDTH(8), .DEPTH(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i1_valid), .in_ready(i1_ready), .in_data(i1_data),
        .flush(f1),
        .out_valid(o1_valid), .out_ready(o1_ready), .out_data(o1_data),
        .occupancy(occ1), .stall_cnt(st1), .stall_clr(clr1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] got [$];
    logic [7:0] t5w [5];
    logic [7:0] t5e [4];
    int         acc;
    logic       exp_rdy;
    logic       ready_now;

    initial begin
        t5w = '{8'h23, 8'h22, 8'h21, 8'h24, 8'h25};
        t5e = '{8'h23, 8'h21, 8'h24, 8'h25};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = '0;
        out_ready = 1'b0; stall_clr = 1'b0;
        i1_valid = 1'b0; i1_data = '0; f1 = '0; o1_ready = 1'b0; clr1 = 1'b0;

        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        chk("rst_occ",       32'(occupancy), 0);
        chk("rst_stall",     32'(stall_cnt), 0);
        chk("rst_d1_ready",  32'(i1_ready), 1);
        rst_n = 1'b1;
        tick();

        // Streaming at full rate, latency DEPTH-1 edges
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 + i);
            tick();
            chk("t2_occ", 32'(occupancy), (i < 4) ? i + 1 : 5);
            chk("t2_out_valid", 32'(out_valid), 32'(i >= 4));
            if (i >= 4) chk("t2_out_data", 32'(out_data), 32'(8'h11 + i - 4));
        end
        in_valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk("t2_drain_occ", 32'(occupancy), 5 - j);
            chk("t2_drain_valid", 32'(out_valid), 32'(j < 5));
            if (j < 5) chk("t2_drain_data", 32'(out_data), 32'(8'h14 + j));
        end

        // Backpressure fill, stall count, then lossless drain
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + acc);
            #1;
            exp_rdy = (acc < 5);
            chk("t3_in_ready", 32'(in_ready), 32'(exp_rdy));
            tick();
            if (exp_rdy) acc++;
        end
        chk("t3_occ_full", 32'(occupancy), 5);
        chk("t3_stall2", 32'(stall_cnt), 2);
        repeat (8) tick();
        chk("t3_stall10", 32'(stall_cnt), 10);
        chk("t3_in_ready_full", 32'(in_ready), 0);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 30 && got.size() < 7; c++) begin
            in_valid = (acc < 7);
            in_data  = 8'(8'h31 + acc);
            #1;
            if (out_valid) got.push_back(out_data);
            ready_now = in_ready;
            tick();
            if (in_valid && ready_now) acc++;
        end
        in_valid = 1'b0;
        chk("t3_count", 32'(got.size()), 7);
        foreach (got[i]) chk("t3_word", 32'(got[i]), 32'(8'h31 + i));
        chk("t3_occ_empty", 32'(occupancy), 0);
        chk("t3_stall_hold", 32'(stall_cnt), 10);

        // Bubble collapse under output stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0A;
        tick();
        in_valid = 1'b0;
        chk("t4_occ0", 32'(occupancy), 1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("t4_occ", 32'(occupancy), 1);
            chk("t4_in_ready", 32'(in_ready), 1);
            chk("t4_out_valid", 32'(out_valid), 32'(j == 4));
        end
        chk("t4_out_data", 32'(out_data), 32'h0A);
        out_ready = 1'b1;
        tick();
        chk("t4_occ_end", 32'(occupancy), 0);
        chk("t4_stall", 32'(stall_cnt), 10);

        // Mid-pipe flush with simultaneous refill
        got.delete();
        for (int c = 0; c < 30 && got.size() < 4; c++) begin
            in_valid = (c < 5);
            if (c < 5) in_data = t5w[c];
            flush = (c == 4) ? 5'b00100 : 5'b00000;
            #1;
            if (out_valid) got.push_back(out_data);
            if (c == 4) chk("t5_in_ready", 32'(in_ready), 1);
            tick();
            if (c == 4) chk("t5_occ_after_flush", 32'(occupancy), 4);
        end
        flush = '0; in_valid = 1'b0;
        chk("t5_count", 32'(got.size()), 4);
        foreach (got[i]) if (i < 4) chk("t5_word", 32'(got[i]), 32'(t5e[i]));
        chk("t5_occ_end", 32'(occupancy), 0);

        // Flushed head never handshakes
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h41;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t5b_head_valid", 32'(out_valid), 1);
        flush = 5'b10000; out_ready = 1'b1;
        #1;
        chk("t5b_flushed_valid", 32'(out_valid), 0);
        tick();
        flush = '0;
        chk("t5b_occ", 32'(occupancy), 0);
        chk("t5b_stall", 32'(stall_cnt), 10);

        // Flush at slot 0 while input is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h51;
        tick();
        in_data = 8'h52;
        flush   = 5'b00001;
        #1;
        chk("t5c_in_ready", 32'(in_ready), 1);
        tick();
        flush = '0; in_valid = 1'b0;
        chk("t5c_occ", 32'(occupancy), 1);
        repeat (4) tick();
        chk("t5c_out_valid", 32'(out_valid), 1);
        chk("t5c_out_data", 32'(out_data), 32'h52);
        out_ready = 1'b1;
        tick();
        chk("t5c_occ_end", 32'(occupancy), 0);

        // Stall counter saturation and clear priority
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("t6_clr0", 32'(stall_cnt), 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h61;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t6_head", 32'(out_valid), 1);
        chk("t6_stall_start", 32'(stall_cnt), 0);
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk("t6_stall", 32'(stall_cnt), (t < 15) ? t : 15);
        end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("t6_clr", 32'(stall_cnt), 0);
        tick();
        chk("t6_after_clr", 32'(stall_cnt), 1);

        // Asynchronous reset with entries held
        in_valid = 1'b1;
        in_data  = 8'h62;
        tick();
        in_data = 8'h63;
        tick();
        in_valid = 1'b0;
        chk("t1_occ_pre", 32'(occupancy), 3);
        chk("t1_stall_pre", 32'(stall_cnt), 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t1_occ", 32'(occupancy), 0);
        chk("t1_stall", 32'(stall_cnt), 0);
        chk("t1_out_valid", 32'(out_valid), 0);
        chk("t1_in_ready", 32'(in_ready), 1);
        chk("t1_out_data", 32'(out_data), 0);
        #2;
        rst_n = 1'b1;
        tick();

        // DEPTH=1 instance
        i1_valid = 1'b1; i1_data = 8'h71; o1_ready = 1'b0;
        tick();
        chk("d1_valid", 32'(o1_valid), 1);
        chk("d1_data", 32'(o1_data), 32'h71);
        chk("d1_occ", 32'(occ1), 1);
        i1_data = 8'h72;
        #1;
        chk("d1_ready_full", 32'(i1_ready), 0);
        o1_ready = 1'b1;
        #1;
        chk("d1_ready_pass", 32'(i1_ready), 1);
        tick();
        chk("d1_data2", 32'(o1_data), 32'h72);
        chk("d1_valid2", 32'(o1_valid), 1);
        chk("d1_stall", 32'(st1), 0);
        i1_valid = 1'b0;
        tick();
        chk("d1_empty", 32'(o1_valid), 0);
        chk("d1_occ0", 32'(occ1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
